alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Parametrised successor of the datapath ALU: registered single-cycle logic/arith/shift ops plus
//  iterative MULT/MULTU/DIV/DIVU writing persistent HI/LO registers. Sits in the execute stage;
//  a valid/ready input handshake stalls issue while a multi-cycle op runs.
// PARAMETERS
//  WIDTH   32  operand/result width; even, >=8; shift amount = src_b[$clog2(WIDTH)-1:0]
//  CTRL_W  4   alu_ctrl width (fixed encoding below; values >=16 not defined)
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  reset_n      in   1      synchronous, active-low reset
//  in_valid     in   1      operands/op presented
//  in_ready     out  1      block can accept; transfer when in_valid & in_ready
//  src_a        in   WIDTH  operand A
//  src_b        in   WIDTH  operand B
//  alu_ctrl     in   CTRL_W operation select
//  out_valid    out  1      one-cycle pulse: result/zero/err valid (hi/lo too for mul/div)
//  result       out  WIDTH  op result (LO for mul/div); held until next out_valid
//  zero         out  1      result == 0, registered with result
//  hi, lo       out  WIDTH  HI/LO regs; change only on mul/div completion
//  err          out  1      with out_valid: illegal op or divide by zero
// BEHAVIOUR
//  Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT(signed),
//   1000 SLL(a<<sh), 1001 SRL, 1010 SRA, 1011 illegal, 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU.
//  Reset (reset_n=0 at edge): state IDLE, out_valid/err/result/hi/lo=0, zero=1, in_ready=1 next cycle.
//   Reset mid-op abandons it: no out_valid, HI/LO cleared.
//  ADD/SUB wrap modulo 2^WIDTH, no overflow flag. SLT/SLTU result is 0 or 1 zero-extended.
//  FSM: IDLE -> (mul/div accepted) RUN -> FIX -> DONE -> IDLE.
//   IDLE: in_ready=1. Single-cycle op accepted at edge N: result/zero/err regs load, out_valid=1
//    during cycle N+1; back-to-back accepts allowed (one result per cycle).
//   RUN: in_ready=0, WIDTH iterations on |operands| (shift-add mul / restoring div), counter
//    WIDTH-1 down to 0; in_valid ignored.
//   FIX: apply signs: MULT product negated if signs differ; DIV quotient negated if signs differ,
//    remainder takes sign of dividend. HI<=product[2W-1:W]/remainder, LO<=product[W-1:0]/quotient.
//   DONE: out_valid=1, result=LO, in_ready=1 (new op may be accepted this cycle).
//   Mul/div latency: accept edge N -> out_valid in cycle N+WIDTH+2.
//  Divide by zero (b==0): same latency, err=1, LO={WIDTH{1'b1}}, HI=src_a.
//  DIV MIN/-1: LO=MIN, HI=0, err=0 (wrap).
//  Illegal 1011: single-cycle, result=0, zero=1, err=1, HI/LO unchanged.
//  Unsigned ops treat operands unsigned; MULTU/DIVU never negate.
// STRUCTURE
//  alu_pkg: op-code localparams, FSM state encoding, OP_IS_MULDIV helper function.
//  Sub-module alu_iter_core: RUN/FIX datapath (abs, accumulator, counter, sign fix), start/done
//   ports; top holds FSM sequencing, single-cycle ops, output and HI/LO registers.
// TESTING (WIDTH=32)
//  ADD 7+5 -> out_valid next cycle, result=12, zero=0; then SUB 5-5 back-to-back -> 0, zero=1.
//  SLT a=FFFFFFFF b=1 -> 1; SLTU same -> 0; SRA 80000000 by 4 -> F8000000; op 1011 -> err=1, result=0.
//  MULT FFFFFFFF*2 -> in_ready low 33 cycles, out_valid at N+34, HI=FFFFFFFF LO=FFFFFFFE.
//  DIV -7/2 -> LO=FFFFFFFD HI=FFFFFFFF; DIVU 9/0 -> err=1 LO=FFFFFFFF HI=9; DIV 80000000/-1 -> LO=80000000 HI=0.
//  in_valid held during RUN -> ignored, no extra out_valid; new op accepted in DONE cycle.
//  reset_n low mid-MULT -> no out_valid, hi=lo=0, zero=1, in_ready=1 cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_muldiv execute-stage block.
//   - 4-bit operation encodings for alu_ctrl
//   - FSM state encoding used by the top-level sequencer
//   - op_is_muldiv(): true for the multi-cycle MULT/MULTU/DIV/DIVU group
package alu_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_XOR     = 4'b0011;
    localparam logic [3:0] OP_NOR     = 4'b0100;
    localparam logic [3:0] OP_SLTU    = 4'b0101;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_SLT     = 4'b0111;
    localparam logic [3:0] OP_SLL     = 4'b1000;
    localparam logic [3:0] OP_SRL     = 4'b1001;
    localparam logic [3:0] OP_SRA     = 4'b1010;
    localparam logic [3:0] OP_ILLEGAL = 4'b1011;
    localparam logic [3:0] OP_MULT    = 4'b1100;
    localparam logic [3:0] OP_MULTU   = 4'b1101;
    localparam logic [3:0] OP_DIV     = 4'b1110;
    localparam logic [3:0] OP_DIVU    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    // The whole 11xx quadrant is the iterative unit.
    function automatic logic op_is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: iterative multiply/divide datapath.
//   start      in   load operands and begin WIDTH iterations on |a|, |b|
//   is_div     in   1 = restoring divide, 0 = shift-add multiply
//   is_signed  in   operands are two's complement (MULT/DIV)
//   a, b       in   operands, sampled only when start is high
//   done       out  high during the final iteration cycle
//   hi, lo     out  sign-fixed HI/LO, valid from the cycle after done
//   div0       out  last divide had a zero divisor
module alu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    // acc_hi/acc_lo hold {partial product, multiplier} for mul and
    // {remainder, dividend/quotient} for div; opd is multiplicand or divisor.
    logic [WIDTH-1:0] acc_hi, acc_lo, opd;
    logic [CNT_W-1:0] cnt;
    logic             running, div_op, neg_q, neg_r, div_zero;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] product;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;
    assign done  = running && (cnt == '0);
    assign div0  = div_zero;

    // NOTE: every variable written in always_comb is given a default first so no latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CNT_W'(WIDTH - 1);
        end else if (running) begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) running <= 1'b0;
        end
    end

    // NOTE: the datapath registers carry no reset; running gates their use and start reloads them.
    always_ff @(posedge clk) begin
        if (start) begin
            div_op   <= is_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= is_div && (b == '0);
            opd      <= is_div ? abs_b : abs_a;
            acc_lo   <= is_div ? abs_a : abs_b;
            acc_hi   <= '0;
        end else if (running) begin
            if (div_op) begin
                if (!div_diff[WIDTH]) begin
                    acc_hi <= div_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Sign fix. A zero divisor naturally leaves remainder = |a| (so HI = a
    // after the dividend-sign fix); only the quotient is forced to all ones.
    always_comb begin
        product = {acc_hi, acc_lo};
        if (neg_q) product = -product;
        hi = product[2*WIDTH-1:WIDTH];
        lo = product[WIDTH-1:0];
        if (div_op) begin
            hi = neg_r ? -acc_hi : acc_hi;
            lo = neg_q ? -acc_lo : acc_lo;
            if (div_zero) lo = '1;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with iterative multiply/divide and HI/LO.
//   clk, reset_n        clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; transfer when both high
//   src_a, src_b        operands
//   alu_ctrl            operation select (see alu_pkg)
//   out_valid           one-cycle pulse: result/zero/err (and hi/lo for mul/div) valid
//   result, zero        registered result (LO for mul/div) and result==0
//   hi, lo              HI/LO registers, written only on mul/div completion
//   err                 illegal op or divide by zero
module alu_muldiv #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [CTRL_W-1:0] alu_ctrl,
    output logic              out_valid,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              err
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(WIDTH);

    state_t           state, state_next;
    logic [3:0]       op;
    logic [SH_W-1:0]  shamt;
    logic             accept, start, is_muldiv;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic             core_done, core_div0;
    logic [WIDTH-1:0] core_hi, core_lo;

    assign op        = alu_ctrl[3:0];
    assign shamt     = src_b[SH_W-1:0];
    assign is_muldiv = op_is_muldiv(op);
    assign accept    = in_valid & in_ready;

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_div    (op[1]),
        .is_signed (op == OP_MULT || op == OP_DIV),
        .a         (src_a),
        .b         (src_b),
        .done      (core_done),
        .hi        (core_hi),
        .lo        (core_lo),
        .div0      (core_div0)
    );

    // Single-cycle operations.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            OP_ILLEGAL: alu_err = 1'b1;
            default: alu_res = '0;
        endcase
    end

    // Sequencer: DONE behaves like IDLE for acceptance so a new op can issue
    // in the same cycle the mul/div result is presented.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        start      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                in_ready   = 1'b1;
                state_next = S_IDLE;
                if (in_valid && is_muldiv) begin
                    start      = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN:   if (core_done) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            err       <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state     <= state_next;
            out_valid <= 1'b0;
            if (state == S_FIX) begin
                hi        <= core_hi;
                lo        <= core_lo;
                result    <= core_lo;
                zero      <= (core_lo == '0);
                err       <= core_div0;
                out_valid <= 1'b1;
            end else if (accept && !is_muldiv) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                err       <= alu_err;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv (WIDTH=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src_a, src_b;
    logic [3:0]   alu_ctrl;
    logic         out_valid;
    logic [W-1:0] result, hi, lo;
    logic         zero, err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .hi        (hi),
        .lo        (lo),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
    endtask

    // Single-cycle op issued from IDLE; result expected in the next cycle.
    task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_err);
        drive(op, a, b);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " zero"}, zero, exp_res == '0);
        chk({tag, " err"}, err, exp_err);
    endtask

    // Multi-cycle op: checks in_ready low time, latency and HI/LO/result/err.
    // With hold=1, in_valid stays high with ADD 1+1 throughout the run; it must
    // be ignored until the DONE cycle, where it is accepted.
    task automatic muldiv(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input logic exp_err, input bit hold);
        int k, lowcnt;
        bit got;
        drive(op, a, b);
        @(negedge clk);
        if (hold) drive(OP_ADD, 32'd1, 32'd1);
        else in_valid = 1'b0;
        k = 1; lowcnt = 0; got = 0;
        while (k <= 60 && !got) begin
            if (out_valid) got = 1;
            else begin
                if (!in_ready) lowcnt++;
                k++;
                @(negedge clk);
            end
        end
        chk({tag, " completed"}, got, 1);
        if (got) begin
            chk({tag, " latency"}, k, W + 2);
            chk({tag, " ready low cycles"}, lowcnt, W + 1);
            chk({tag, " hi"}, hi, exp_hi);
            chk({tag, " lo"}, lo, exp_lo);
            chk({tag, " result"}, result, exp_lo);
            chk({tag, " zero"}, zero, exp_lo == '0);
            chk({tag, " err"}, err, exp_err);
            chk({tag, " ready in done"}, in_ready, 1);
        end
        @(negedge clk);
        if (hold) begin
            in_valid = 1'b0;
            chk({tag, " held op out_valid"}, out_valid, 1);
            chk({tag, " held op result"}, result, 32'd2);
            chk({tag, " held op keeps hi"}, hi, exp_hi);
            @(negedge clk);
        end
        chk({tag, " idle out_valid"}, out_valid, 0);
    endtask

    initial begin
        int pulses;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        alu_ctrl = OP_AND;
        src_a    = '0;
        src_b    = '0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset zero", zero, 1);
        chk("reset err", err, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", in_ready, 1);

        // Back-to-back ADD then SUB.
        drive(OP_ADD, 32'd7, 32'd5);
        @(negedge clk);
        chk("add out_valid", out_valid, 1);
        chk("add result", result, 32'd12);
        chk("add zero", zero, 0);
        drive(OP_SUB, 32'd5, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sub out_valid", out_valid, 1);
        chk("sub result", result, 32'd0);
        chk("sub zero", zero, 1);
        @(negedge clk);
        chk("pulse ends", out_valid, 0);

        single("slt",      OP_SLT,     32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
        single("sltu",     OP_SLTU,    32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
        single("sra",      OP_SRA,     32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
        single("srl",      OP_SRL,     32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0);
        single("sll mask", OP_SLL,     32'd1,         32'h0000_0021, 32'd2,         1'b0);
        single("and",      OP_AND,     32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
        single("or",       OP_OR,      32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0);
        single("xor",      OP_XOR,     32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
        single("nor",      OP_NOR,     32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0);
        single("add wrap", OP_ADD,     32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
        single("sub wrap", OP_SUB,     32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0);
        single("illegal",  OP_ILLEGAL, 32'd5,         32'd3,         32'd0,         1'b1);

        muldiv("mult",     OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
        muldiv("multu",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        muldiv("div neg",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        muldiv("div negb", OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 1'b0);
        muldiv("divu by0", OP_DIVU,  32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF, 1'b1, 1'b0);
        muldiv("div min",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0);

        single("illegal after div", OP_ILLEGAL, 32'd1, 32'd1, 32'd0, 1'b1);
        chk("illegal keeps hi", hi, 32'd0);
        chk("illegal keeps lo", lo, 32'h8000_0000);

        muldiv("divu",     OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0);

        // Reset in the middle of a MULT abandons it.
        drive(OP_MULT, 32'd3, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid-op busy", in_ready, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort out_valid", out_valid, 0);
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        chk("abort zero", zero, 1);
        chk("abort result", result, 0);
        @(negedge clk);
        chk("abort ready", in_ready, 1);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort no late out_valid", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
